// File: rtl/regfile_wb_ctrl.sv
// Generic FIFO with per-slot occupancy and a tag view of every slot.
// Latency: a pushed entry is visible at the head one edge after the push.
// Backpressure: none internally; the owner must gate push on count < DEPTH.
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 36,
  parameter int TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdat,
  output logic [W-1:0]             rdat,
  output logic [$clog2(DEPTH):0]   count,
  output logic [DEPTH-1:0]         slot_vld,
  output logic [DEPTH*TAG_W-1:0]   slot_tag
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Pointer/count bookkeeping; push and pop together leave the count unchanged.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = wdat;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers; storage is cleared so nothing stale survives a reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign rdat  = mem_q[rd_ptr_q];
  assign count = cnt_q;

  // A slot is live when its distance from the read pointer is below the count.
  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    logic [PW-1:0] off;
    assign off                       = PW'(i) - rd_ptr_q;
    assign slot_vld[i]               = ({1'b0, off} < cnt_q);
    assign slot_tag[i*TAG_W +: TAG_W] = mem_q[i][W-1 -: TAG_W];
  end
endmodule

// Register-file writeback controller: buffers ALU and load results, issues one write per cycle.
// Latency: accept at edge E, pop at E+1, we=1 in the following cycle (regfile commits at E+2).
// Backpressure: xx_ready = FIFO not full from the registered count; a same-cycle pop does not raise it.
module regfile_wb_ctrl #(
  parameter int DEPTH  = 2,
  parameter int DROP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [3:0]        alu_rd,
  input  logic [31:0]       alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [3:0]        mem_rd,
  input  logic [31:0]       mem_data,
  output logic [3:0]        wp,
  output logic              we,
  output logic [31:0]       din,
  output logic [15:0]       busy_mask,
  output logic [DROP_W-1:0] drop_cnt
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = 36;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic {SRC_ALU = 1'b0, SRC_MEM = 1'b1} src_e;

  logic [CW-1:0]       alu_cnt, mem_cnt;
  logic [EW-1:0]       alu_head, mem_head;
  logic [DEPTH-1:0]    alu_vld, mem_vld;
  logic [DEPTH*4-1:0]  alu_tags, mem_tags;
  logic                alu_fire, mem_fire, alu_drop, mem_drop, alu_push, mem_push;
  logic                grant_alu, grant_mem;
  src_e                last_grant_q, last_grant_d;
  logic                we_q, we_d;
  logic [3:0]          wp_q, wp_d;
  logic [31:0]         din_q, din_d;
  logic [DROP_W-1:0]   drop_cnt_q, drop_cnt_d;
  logic [1:0]          drop_inc;
  logic [DROP_W:0]     drop_sum;
  logic [15:0]         busy_c;

  // Ready is forced low while reset is held so nothing is accepted into a clearing FIFO.
  assign alu_ready = rst & (alu_cnt < FULL_CNT);
  assign mem_ready = rst & (mem_cnt < FULL_CNT);

  // Writes to r0/r15 complete the handshake but are never stored.
  assign alu_fire = alu_valid & alu_ready;
  assign mem_fire = mem_valid & mem_ready;
  assign alu_drop = alu_fire & ((alu_rd == 4'h0) | (alu_rd == 4'hF));
  assign mem_drop = mem_fire & ((mem_rd == 4'h0) | (mem_rd == 4'hF));
  assign alu_push = alu_fire & ~alu_drop;
  assign mem_push = mem_fire & ~mem_drop;

  wb_fifo #(.DEPTH(DEPTH), .W(EW), .TAG_W(4)) u_alu_fifo (
    .clk      (clk),
    .rst_n    (rst),
    .push     (alu_push),
    .pop      (grant_alu),
    .wdat     ({alu_rd, alu_data}),
    .rdat     (alu_head),
    .count    (alu_cnt),
    .slot_vld (alu_vld),
    .slot_tag (alu_tags)
  );

  wb_fifo #(.DEPTH(DEPTH), .W(EW), .TAG_W(4)) u_mem_fifo (
    .clk      (clk),
    .rst_n    (rst),
    .push     (mem_push),
    .pop      (grant_mem),
    .wdat     ({mem_rd, mem_data}),
    .rdat     (mem_head),
    .count    (mem_cnt),
    .slot_vld (mem_vld),
    .slot_tag (mem_tags)
  );

  // Arbitration: an uncontested head always wins; on contention alternate against the
  // last contested winner, which is the only case that updates last_grant.
  always_comb begin
    grant_alu    = 1'b0;
    grant_mem    = 1'b0;
    last_grant_d = last_grant_q;
    if ((alu_cnt != '0) && (mem_cnt != '0)) begin
      if (last_grant_q == SRC_MEM) begin
        grant_alu = 1'b1;
      end else begin
        grant_mem = 1'b1;
      end
      last_grant_d = grant_alu ? SRC_ALU : SRC_MEM;
    end else begin
      grant_alu = (alu_cnt != '0);
      grant_mem = (mem_cnt != '0);
    end
  end

  // Output stage next state: load the granted head, otherwise drop we and hold wp/din.
  always_comb begin
    we_d  = grant_alu | grant_mem;
    wp_d  = wp_q;
    din_d = din_q;
    if (grant_alu) begin
      {wp_d, din_d} = alu_head;
    end else if (grant_mem) begin
      {wp_d, din_d} = mem_head;
    end
  end

  // Saturating drop counter; both sources may drop in the same cycle.
  always_comb begin
    drop_inc   = {1'b0, alu_drop} + {1'b0, mem_drop};
    drop_sum   = {1'b0, drop_cnt_q} + {{(DROP_W-1){1'b0}}, drop_inc};
    drop_cnt_d = drop_sum[DROP_W] ? {DROP_W{1'b1}} : drop_sum[DROP_W-1:0];
  end

  // Controller state; the asynchronous clear kills any in-flight write immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_q <= SRC_MEM;
      we_q         <= 1'b0;
      wp_q         <= '0;
      din_q        <= '0;
      drop_cnt_q   <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      wp_q         <= wp_d;
      din_q        <= din_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  // Pending-write mask: every live FIFO entry plus the write currently on the port.
  always_comb begin
    busy_c = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (alu_vld[i]) busy_c[alu_tags[i*4 +: 4]] = 1'b1;
      if (mem_vld[i]) busy_c[mem_tags[i*4 +: 4]] = 1'b1;
    end
    if (we_q) busy_c[wp_q] = 1'b1;
    busy_c[0]  = 1'b0;
    busy_c[15] = 1'b0;
  end

  assign busy_mask = busy_c;
  assign we        = we_q;
  assign wp        = wp_q;
  assign din       = din_q;
  assign drop_cnt  = drop_cnt_q;
endmodule
